// File: rtl/icache_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_fetcher
// Brief    : Fetches one BANK_NUM-word line from memory and returns it packed.
// Revision : 1.0
// ============================================================================
module icache_line_fetcher #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_NUM   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rd_req,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic                           rd_ready,
    input  logic                           flush,
    output logic                           ret_valid,
    output logic [BANK_NUM*DATA_WIDTH-1:0] ret_data,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int C_LINE_W     = BANK_NUM * DATA_WIDTH;
    localparam int C_WORD_BYTES = DATA_WIDTH / 8;
    localparam int C_CNT_W      = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int C_OFF_W      = $clog2(BANK_NUM * C_WORD_BYTES);
    localparam int C_WOFF_W     = $clog2(C_WORD_BYTES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(BANK_NUM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [C_CNT_W-1:0]    cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] base_q,      base_d;
    logic [C_LINE_W-1:0]   stage_q,     stage_d;
    logic [C_LINE_W-1:0]   ret_data_q,  ret_data_d;
    logic                  drop_q,      drop_d;
    logic                  rd_ready_q,  rd_ready_d;
    logic                  ret_valid_q, ret_valid_d;
    logic                  mem_req_q,   mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [C_LINE_W-1:0]   w_line;
    logic                  w_unused_addr_bits;

    assign w_unused_addr_bits = ^rd_addr[C_OFF_W-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        stage_d    = stage_q;
        ret_data_d = ret_data_q;

        // Staged line with the incoming beat merged; ret_data only sees it on the final beat.
        w_line = stage_q;
        w_line[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;

        case (state_q)
            IDLE: begin
                if (rd_req && !flush) begin
                    base_d  = {rd_addr[ADDR_WIDTH-1:C_OFF_W], {C_OFF_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = flush ? DRAIN : WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        stage_d = w_line;
                        if (cnt_q == C_CNT_LAST) begin
                            ret_data_d = w_line;
                            state_d    = DONE;
                        end else begin
                            cnt_d   = cnt_q + C_CNT_W'(1);
                            state_d = REQ;
                        end
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                // drop_q marks a granted beat still owed by memory
                if (mem_rvalid || !drop_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drop_d      = (state_d == DRAIN);
        rd_ready_d  = (state_d == IDLE);
        ret_valid_d = (state_d == DONE);
        mem_req_d   = (state_d == REQ);
        mem_addr_d  = (state_d == REQ)
                    ? base_d + ADDR_WIDTH'({cnt_d, {C_WOFF_W{1'b0}}})
                    : mem_addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            stage_q     <= '0;
            ret_data_q  <= '0;
            drop_q      <= 1'b0;
            rd_ready_q  <= 1'b1;
            ret_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            stage_q     <= stage_d;
            ret_data_q  <= ret_data_d;
            drop_q      <= drop_d;
            rd_ready_q  <= rd_ready_d;
            ret_valid_q <= ret_valid_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign rd_ready  = rd_ready_q;
    assign ret_valid = ret_valid_q;
    assign ret_data  = ret_data_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_line_fetcher
// Brief    : Scoreboard bench for icache_line_fetcher with a scripted memory.
// Revision : 1.0
// ============================================================================
module tb_icache_line_fetcher;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_ready;
    logic         flush;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  pat     = 32'h0;
    logic [255:0] last_line = '0;
    logic [255:0] exp_q[$];

    icache_line_fetcher #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BANK_NUM  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .flush     (flush),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ pat;
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = a & ~32'h1F;
        l = '0;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(base + 32'(4*k));
        return l;
    endfunction

    // Every returned line is matched against the oldest expected line.
    always @(negedge clk) begin
        logic [255:0] e;
        if (reset && ret_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_ret_valid", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("ret_data", ret_data, e);
            end
        end
    end

    task automatic start(input logic [31:0] a, input bit push);
        check("rd_ready_idle", rd_ready, 1'b1);
        rd_req  = 1'b1;
        rd_addr = a;
        if (push) exp_q.push_back(exp_line(a));
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input int stall, input bit busy);
        for (int s = 0; s < stall; s++) begin
            check("mem_req_stall", mem_req, 1'b1);
            check("mem_addr_stall", mem_addr, a);
            @(negedge clk);
        end
        check("mem_req", mem_req, 1'b1);
        check("mem_addr", mem_addr, a);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("mem_req_drop", mem_req, 1'b0);
        if (busy) begin
            check("rd_ready_busy", rd_ready, 1'b0);
            rd_req  = 1'b1;
            rd_addr = 32'h2000_0000;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(a);
        @(negedge clk);
        mem_rvalid = 1'b0;
        rd_req     = 1'b0;
    endtask

    task automatic finish_fetch(input logic [255:0] line);
        check("ret_valid_pulse", ret_valid, 1'b1);
        check("rd_ready_done", rd_ready, 1'b0);
        last_line = line;
        @(negedge clk);
        check("ret_valid_single", ret_valid, 1'b0);
        check("rd_ready_after", rd_ready, 1'b1);
        check("mem_req_after", mem_req, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_rd_ready", rd_ready, 1'b1);
        check("rst_ret_valid", ret_valid, 1'b0);
        check("rst_ret_data", ret_data, 256'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // flush beats a simultaneous request in IDLE
        flush   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 32'h4000_0000;
        @(negedge clk);
        flush  = 1'b0;
        rd_req = 1'b0;
        check("flush_idle_mem_req", mem_req, 1'b0);
        check("flush_idle_rd_ready", rd_ready, 1'b1);

        // basic zero-wait fetch: ret_valid 17 cycles after accept
        start(32'h1000_0014, 1'b1);
        for (int k = 0; k < 8; k++) beat(32'h1000_0000 + 32'(4*k), 0, 1'b0);
        finish_fetch(exp_line(32'h1000_0000));

        // grant stall on beat 2, busy request on beat 4
        pat = 32'hA5A5_5A5A;
        start(32'h1000_0000, 1'b1);
        for (int k = 0; k < 8; k++) beat(32'h1000_0000 + 32'(4*k), (k == 2) ? 3 : 0, k == 4);
        finish_fetch(exp_line(32'h1000_0000));

        // flush in WAIT before rvalid, beat arrives two cycles later
        pat = 32'h0F0F_F0F0;
        start(32'h3000_0040, 1'b0);
        for (int k = 0; k < 5; k++) beat(32'h3000_0040 + 32'(4*k), 0, 1'b0);
        check("fw_mem_req", mem_req, 1'b1);
        check("fw_mem_addr", mem_addr, 32'h3000_0054);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fw_drain_rd_ready", rd_ready, 1'b0);
        @(negedge clk);
        check("fw_drain_rd_ready2", rd_ready, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("fw_rd_ready", rd_ready, 1'b1);
        check("fw_ret_valid", ret_valid, 1'b0);
        check("fw_ret_data_kept", ret_data, last_line);
        check("fw_mem_req", mem_req, 1'b0);

        // flush in REQ with no grant
        pat = 32'h1234_5678;
        start(32'h5000_0000, 1'b0);
        beat(32'h5000_0000, 0, 1'b0);
        check("fr_mem_req", mem_req, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fr_mem_req_off", mem_req, 1'b0);
        check("fr_rd_ready", rd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fr_no_traffic", mem_req, 1'b0);
        end
        check("fr_ret_data_kept", ret_data, last_line);

        // asynchronous reset at beat 3, between clock edges
        start(32'h6000_0020, 1'b0);
        for (int k = 0; k < 3; k++) beat(32'h6000_0020 + 32'(4*k), 0, 1'b0);
        check("ar_mem_req", mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar_mem_req_off", mem_req, 1'b0);
        check("ar_ret_valid", ret_valid, 1'b0);
        check("ar_ret_data", ret_data, 256'h0);
        check("ar_rd_ready", rd_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pat = 32'hFFFF_0000;
        start(32'h7000_003C, 1'b1);
        for (int k = 0; k < 8; k++) beat(32'h7000_0020 + 32'(4*k), (k == 7) ? 1 : 0, 1'b0);
        finish_fetch(exp_line(32'h7000_0020));

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
